// File: rtl/result_mem_slave_if.sv
// rtl/result_mem_slave_if.sv - master-port bus bundle for the result memory slave
interface result_mem_slave_if;
    logic        M_req;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_din;
    logic        M_grant;
    logic [31:0] M_dout;

    modport master (
        output M_req,
        output M_wr,
        output M_address,
        output M_din,
        input  M_grant,
        input  M_dout
    );

    modport slave (
        input  M_req,
        input  M_wr,
        input  M_address,
        input  M_din,
        output M_grant,
        output M_dout
    );
endinterface

// File: rtl/result_mem_slave.sv
// rtl/result_mem_slave.sv - 16-word result store filled by a bus master, read by a host, irq on full set
module result_mem_slave #(
    parameter logic [7:0]  BASE_ADDR = 8'h20,
    parameter int unsigned EXPECT    = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    result_mem_slave_if.slave        m_bus,
    input  logic                     H_rd,
    input  logic [3:0]               H_address,
    output logic [31:0]              H_dout,
    input  logic                     irq_clr,
    output logic                     done,
    output logic                     irq,
    output logic                     err,
    output logic [4:0]               wr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic        grant_q;
    logic [31:0] m_dout_q;
    logic [31:0] h_dout_q;
    logic        done_q;
    logic        irq_q;
    logic        err_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [15:0] valid_q;
    logic [31:0] mem_q [16];

    logic [8:0]  win_lo;
    logic [8:0]  win_hi;
    logic [8:0]  addr_ext;
    logic        in_win;
    logic [3:0]  idx;
    logic        access;
    logic        wr_hit;
    logic        rd_hit;
    logic        new_word;
    logic        completes;

    // Window bounds are computed one bit wider so BASE_ADDR near 8'hFF cannot wrap.
    assign win_lo   = {1'b0, BASE_ADDR};
    assign win_hi   = {1'b0, BASE_ADDR} + 9'd16;
    assign addr_ext = {1'b0, m_bus.M_address};
    assign in_win   = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign idx      = 4'(m_bus.M_address - BASE_ADDR);

    assign access    = (state_q == S_GRANT) && m_bus.M_req;
    assign wr_hit    = access && m_bus.M_wr && in_win;
    assign rd_hit    = access && !m_bus.M_wr && in_win;
    assign new_word  = wr_hit && !valid_q[idx];
    assign cnt_d     = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
    assign completes = new_word && (32'(cnt_d) == EXPECT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            m_dout_q <= 32'h0;
            h_dout_q <= 32'h0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 5'd0;
            valid_q  <= 16'h0;
        end else begin
            // Nonblocking read of mem_q returns pre-write data on a same-cycle collision.
            if (H_rd) begin
                h_dout_q <= mem_q[H_address];
            end

            case (state_q)
                S_IDLE: begin
                    if (m_bus.M_req) begin
                        state_q <= S_GRANT;
                        grant_q <= 1'b1;
                    end
                end

                S_GRANT: begin
                    if (!m_bus.M_req) begin
                        state_q <= S_IDLE;
                        grant_q <= 1'b0;
                    end else begin
                        if (rd_hit) begin
                            m_dout_q <= mem_q[idx];
                        end
                        if (!in_win) begin
                            err_q <= 1'b1;
                        end
                        if (new_word) begin
                            valid_q[idx] <= 1'b1;
                            cnt_q        <= cnt_d;
                        end
                        if (completes) begin
                            state_q <= S_DONE;
                            grant_q <= 1'b0;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (irq_clr) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        irq_q   <= 1'b0;
                        err_q   <= 1'b0;
                        cnt_q   <= 5'd0;
                        valid_q <= 16'h0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    // Data words carry no reset; reset only blocks a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset_n && wr_hit) begin
            mem_q[idx] <= m_bus.M_din;
        end
    end

    assign m_bus.M_grant = grant_q;
    assign m_bus.M_dout  = m_dout_q;
    assign H_dout        = h_dout_q;
    assign done          = done_q;
    assign irq           = irq_q;
    assign err           = err_q;
    assign wr_cnt        = cnt_q;

endmodule

// File: tb/tb_result_mem_slave.sv
// tb/tb_result_mem_slave.sv - table-driven bench with read-data scoreboard for result_mem_slave
module tb_result_mem_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        H_rd;
    logic [3:0]  H_address;
    logic [31:0] H_dout;
    logic        irq_clr;
    logic        done;
    logic        irq;
    logic        err;
    logic [4:0]  wr_cnt;

    always #5 clk = ~clk;

    result_mem_slave_if bus ();

    result_mem_slave #(
        .BASE_ADDR (8'h20),
        .EXPECT    (9)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_bus     (bus),
        .H_rd      (H_rd),
        .H_address (H_address),
        .H_dout    (H_dout),
        .irq_clr   (irq_clr),
        .done      (done),
        .irq       (irq),
        .err       (err),
        .wr_cnt    (wr_cnt)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] din;
        logic        hrd;
        logic [3:0]  haddr;
        logic        clr;
        logic        st;
        logic        rd;
        logic        g;
        logic [4:0]  cnt;
        logic        e;
        logic        d;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] m_q[$];
    logic [31:0] h_q[$];
    logic [31:0] mem_m [16];
    logic [31:0] exp_md = 32'h0;
    logic [31:0] exp_hd = 32'h0;
    int          nchk = 0;
    int          nfail = 0;
    int          row = 0;

    function automatic vec_t mk(input logic rst, input logic req, input logic wr,
                                input logic [7:0] addr, input logic [31:0] din,
                                input logic hrd, input logic [3:0] haddr, input logic clr,
                                input logic st, input logic rd, input logic g,
                                input logic [4:0] cnt, input logic e, input logic d);
        vec_t v;
        v.rst = rst; v.req = req; v.wr = wr; v.addr = addr; v.din = din;
        v.hrd = hrd; v.haddr = haddr; v.clr = clr; v.st = st; v.rd = rd;
        v.g = g; v.cnt = cnt; v.e = e; v.d = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL row %0d %s: got %h, expected %h", row, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [7:0] off;
        off         = v.addr - 8'h20;
        reset_n     = ~v.rst;
        bus.M_req   = v.req;
        bus.M_wr    = v.wr;
        bus.M_address = v.addr;
        bus.M_din   = v.din;
        H_rd        = v.hrd;
        H_address   = v.haddr;
        irq_clr     = v.clr;
        if (v.rd)  m_q.push_back(mem_m[off[3:0]]);
        if (v.hrd) h_q.push_back(mem_m[v.haddr]);
        if (v.st)  mem_m[off[3:0]] = v.din;
        @(posedge clk);
        #1;
        if (v.rst) begin
            exp_md = 32'h0;
            exp_hd = 32'h0;
        end
        if (v.rd)  exp_md = m_q.pop_front();
        if (v.hrd) exp_hd = h_q.pop_front();
        chk("M_grant", 32'(bus.M_grant), 32'(v.g));
        chk("wr_cnt",  32'(wr_cnt),      32'(v.cnt));
        chk("err",     32'(err),         32'(v.e));
        chk("done",    32'(done),        32'(v.d));
        chk("irq",     32'(irq),         32'(v.d));
        chk("M_dout",  bus.M_dout,       exp_md);
        chk("H_dout",  H_dout,           exp_hd);
        row++;
    endtask

    initial begin
        // Reset, request cycle, duplicate/out-of-window writes, collisions, full set, clear.
        tbl.push_back(mk(1,0,0,8'h00,32'h0,   0,4'd0,0, 0,0, 0,5'd0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,32'h0,   0,4'd0,0, 0,0, 0,5'd0,0,0));
        tbl.push_back(mk(0,1,1,8'h20,32'h55,  0,4'd0,0, 0,0, 1,5'd0,0,0));
        tbl.push_back(mk(0,1,1,8'h21,32'hAAAA,0,4'd0,0, 1,0, 1,5'd1,0,0));
        tbl.push_back(mk(0,1,1,8'h21,32'hBBBB,0,4'd0,0, 1,0, 1,5'd1,0,0));
        tbl.push_back(mk(0,1,0,8'h21,32'h0,   1,4'd1,0, 0,1, 1,5'd1,0,0));
        tbl.push_back(mk(0,1,1,8'h30,32'hDEAD,0,4'd0,0, 0,0, 1,5'd1,1,0));
        tbl.push_back(mk(0,1,0,8'h1F,32'h0,   0,4'd0,0, 0,0, 1,5'd1,1,0));
        tbl.push_back(mk(0,1,1,8'h21,32'hCCCC,1,4'd1,0, 1,0, 1,5'd1,1,0));
        tbl.push_back(mk(0,1,0,8'h21,32'h0,   0,4'd0,0, 0,1, 1,5'd1,1,0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,   0,4'd0,0, 0,0, 0,5'd1,1,0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,   0,4'd0,1, 0,0, 0,5'd1,1,0));
        tbl.push_back(mk(0,1,1,8'h2F,32'h77,  0,4'd0,0, 0,0, 1,5'd1,1,0));
        tbl.push_back(mk(0,1,1,8'h20,32'h100, 0,4'd0,0, 1,0, 1,5'd2,1,0));
        for (int i = 2; i <= 8; i++) begin
            tbl.push_back(mk(0,1,1,8'(8'h20 + i),32'(32'h100 + i),0,4'd0,0, 1,0,
                             (i != 8),5'(i + 1),1,(i == 8)));
        end
        tbl.push_back(mk(0,1,1,8'h29,32'h999, 0,4'd0,0, 0,0, 0,5'd9,1,1));
        tbl.push_back(mk(0,1,0,8'h22,32'h0,   1,4'd3,0, 0,0, 0,5'd9,1,1));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,   0,4'd0,1, 0,0, 0,5'd0,0,0));
        tbl.push_back(mk(0,1,0,8'h22,32'h0,   0,4'd0,0, 0,0, 1,5'd0,0,0));
        tbl.push_back(mk(0,1,0,8'h22,32'h0,   1,4'd1,0, 0,1, 1,5'd0,0,0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,   0,4'd0,0, 0,0, 0,5'd0,0,0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
        end

        // Grant handshake: request held four cycles of reads, grant tracks it one edge late.
        apply(mk(0,1,0,8'h22,32'h0,0,4'd0,0, 0,0, 1,5'd0,0,0));
        for (int i = 3; i <= 5; i++) begin
            apply(mk(0,1,0,8'(8'h20 + i),32'h0,0,4'd0,0, 0,1, 1,5'd0,0,0));
        end
        apply(mk(0,0,0,8'h00,32'h0,0,4'd0,0, 0,0, 0,5'd0,0,0));

        // Reset in the middle of a burst, overriding the write presented with it.
        apply(mk(0,1,1,8'h20,32'h200,0,4'd0,0, 0,0, 1,5'd0,0,0));
        for (int i = 0; i < 5; i++) begin
            apply(mk(0,1,1,8'(8'h20 + i),32'(32'h200 + i),0,4'd0,0, 1,0, 1,5'(i + 1),0,0));
        end
        apply(mk(1,1,1,8'h25,32'hBAD,0,4'd0,0, 0,0, 0,5'd0,0,0));
        apply(mk(0,0,0,8'h00,32'h0,  1,4'd5,0, 0,0, 0,5'd0,0,0));

        // A full set after the aborted burst completes normally.
        apply(mk(0,1,1,8'h28,32'h0,0,4'd0,0, 0,0, 1,5'd0,0,0));
        for (int i = 0; i <= 8; i++) begin
            apply(mk(0,1,1,8'(8'h20 + i),32'(32'h300 + i),0,4'd0,0, 1,0,
                     (i != 8),5'(i + 1),0,(i == 8)));
        end
        apply(mk(0,1,1,8'h21,32'h0,1,4'd8,0, 0,0, 0,5'd9,0,1));
        apply(mk(0,0,0,8'h00,32'h0,0,4'd0,1, 0,0, 0,5'd0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/result_mem_slave.md
RESULT_MEM_SLAVE -- requirements
Module: result_mem_slave

Interface
REQ-001 Parameter BASE_ADDR, default 8'h20: base of the 16-word window accepted on the M-port.
REQ-002 Parameter EXPECT, default 9: number of distinct words that completes a result set.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 M_req  input  1  master bus request.
REQ-006 M_wr  input  1  1 = write, 0 = read, qualified by M_req and M_grant.
REQ-007 M_address  input  8  master byte-free word address.
REQ-008 M_din  input  32  master write data.
REQ-009 M_grant  output  1  bus grant to master, registered.
REQ-010 M_dout  output  32  master read data, registered.
REQ-011 H_rd  input  1  host read strobe.
REQ-012 H_address  input  4  host word index.
REQ-013 H_dout  output  32  host read data, registered.
REQ-014 irq_clr  input  1  host interrupt acknowledge.
REQ-015 done  output  1  result set complete.
REQ-016 irq  output  1  interrupt, level, sticky until cleared.
REQ-017 err  output  1  sticky out-of-window access flag.
REQ-018 wr_cnt  output  5  count of distinct words written.

Function
REQ-019 Storage: 16 x 32-bit words plus 16-bit valid mask; index = M_address - BASE_ADDR (low 4 bits) when in window.
REQ-020 FSM states IDLE, GRANT, DONE; M_grant = 1 only in GRANT.
REQ-021 IDLE: M_req=1 -> GRANT next edge; no access is performed in the request cycle.
REQ-022 GRANT: each cycle with M_req=1 is one access; M_req=0 -> IDLE next edge, M_grant drops that edge.
REQ-023 GRANT write (M_wr=1, in window): word stored; if valid bit clear, bit set and wr_cnt +1; rewrite overwrites data, wr_cnt unchanged.
REQ-024 GRANT read (M_wr=0, in window): M_dout = stored word one cycle later; M_dout holds otherwise.
REQ-025 Out-of-window access (M_address < BASE_ADDR or >= BASE_ADDR+16): no store, no count, err=1 next edge.
REQ-026 When the write that makes wr_cnt equal EXPECT is accepted: next edge state DONE, done=1, irq=1, M_grant=0, regardless of M_req.
REQ-027 DONE: all M-port accesses ignored, M_grant held 0; irq_clr=1 -> irq=0, done=0, err=0, wr_cnt=0, valid mask cleared, state IDLE next edge; data words retained.
REQ-028 irq_clr outside DONE is ignored.
REQ-029 H_rd=1: H_dout = word[H_address] next edge, any state; H_dout holds otherwise.
REQ-030 Host read and master write to the same word in the same cycle: H_dout returns the pre-write data.
REQ-031 wr_cnt saturates at 16; EXPECT > 16 means done never asserts.

Reset
REQ-032 reset_n=0 at a rising edge: state IDLE, M_grant=0, M_dout=0, H_dout=0, done=0, irq=0, err=0, wr_cnt=0, valid mask cleared, and it overrides any access in the same cycle.
REQ-033 Data words are not reset; reads of unwritten words return undefined data.
REQ-034 Reset asserted mid-burst aborts the burst; master observes M_grant=0 on the following edge.

Verification
REQ-035 Grant handshake: M_req rises at cycle 0 -> M_grant=1 at cycle 1; M_req falls at cycle 4 -> M_grant=0 at cycle 5.
REQ-036 Full set: 9 writes 0x20..0x28 data 0x100+i -> done=irq=1 the edge after the 9th write, M_grant=0; H_rd index 3 returns 0x103.
REQ-037 Duplicate write: writes to 0x21 twice (0xAAAA then 0xBBBB) -> wr_cnt=1, word 1 reads 0xBBBB on both ports.
REQ-038 Out of window: write to 0x30 in GRANT -> err=1, wr_cnt unchanged, no word changed.
REQ-039 Clear: irq_clr in DONE -> irq=done=err=wr_cnt=0, state IDLE; new M_req granted one cycle later; irq_clr in IDLE has no effect.
REQ-040 Reset mid-burst after 5 writes -> all flags 0, wr_cnt=0, M_grant=0 next edge; a full 9-write set afterwards completes normally.
